// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Bundle of the start/busy/done handshake and data between a requester and
// the bit-serial adder controller.
//   start     : request; sampled only while the controller is idle
//   a, b, cin : operands and initial carry, captured on the accepted start
//   busy      : controller is running or presenting a result
//   done      : one-cycle pulse, result valid
//   sum       : registered WIDTH-bit result
//   cout, ovf : registered final carry and signed overflow
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller. Sequences one combinational 1-bit full-adder
// cell over a WIDTH-bit operand pair, LSB first, one bit per clock. The
// ripple carry lives in a register between cycles. Sum, carry-out and signed
// overflow are registered and only change on the cycle the result completes.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (priority over start)
//   bus : serial_adder_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout/ovf out)
// Latency: start accepted in cycle 0, done in cycle WIDTH+1, next accept in
// cycle WIDTH+2.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sr_r;
  logic             c_r;
  logic             cm_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [1:0]       fa_s;
  logic             s_s;
  logic             co_s;
  logic [WIDTH-1:0] result_s;

  // 1-bit full-adder cell; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Shared full-adder cell on the current LSBs and the carry register.
  always_comb begin
    fa_s     = full_add(sa_r[0], sb_r[0], c_r);
    s_s      = fa_s[0];
    co_s     = fa_s[1];
    result_s = {s_s, sr_r[WIDTH-1:1]};
  end

  // Controller state, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      sr_r    <= '0;
      c_r     <= 1'b0;
      cm_r    <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            sa_r    <= bus.a;
            sb_r    <= bus.b;
            c_r     <= bus.cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_r <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r <= {1'b0, sb_r[WIDTH-1:1]};
          sr_r <= result_s;
          c_r  <= co_s;
          // Carry leaving bit WIDTH-2 is the carry into the MSB; keep it for
          // the overflow decision on the following (MSB) step.
          if (cnt_r == CNT_PEN) begin
            cm_r <= co_s;
          end else begin
            cm_r <= cm_r;
          end
          if (cnt_r == CNT_LAST) begin
            // Counter is held here so it never wraps for power-of-two WIDTH.
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            sum_r   <= result_s;
            cout_r  <= co_s;
            ovf_r   <= co_s ^ cm_r;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          // Any start seen here is dropped, not queued.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
